// File: rtl/stereo_router.sv
// stereo_router: routes L/R samples per aural_state (11 stereo, 10 left, 01 right, 00 mute) with per-channel gain ramps when STEREO_ROUTER_RAMP_EN is defined; ports clk, rst, aural_state, new_sample, left_in, right_in -> left_out, right_out, out_valid, settled
module stereo_router #(
  parameter int WIDTH = 16,
  parameter int RAMP_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       aural_state,
  input  logic             new_sample,
  input  logic [WIDTH-1:0] left_in,
  input  logic [WIDTH-1:0] right_in,
  output logic [WIDTH-1:0] left_out,
  output logic [WIDTH-1:0] right_out,
  output logic             out_valid,
  output logic             settled
);
  localparam int P = WIDTH + RAMP_BITS + 2;
  localparam logic [RAMP_BITS:0] GMAX = {1'b1, {RAMP_BITS{1'b0}}};
  logic [RAMP_BITS:0] tl, tr, gl, gr;
  assign tl = aural_state[1] ? GMAX : '0;
  assign tr = aural_state[0] ? GMAX : '0;
  function automatic logic [WIDTH-1:0] scale(input logic [WIDTH-1:0] s, input logic [RAMP_BITS:0] g);
    logic signed [P-1:0] a, b;
    a = P'($signed(s));
    b = P'(g);
    return WIDTH'((a * b) >>> RAMP_BITS);
  endfunction
`ifdef STEREO_ROUTER_RAMP_EN
  typedef enum logic [1:0] {HOLD, UP, DOWN} ramp_t;
  ramp_t sl, sr, sl_n, sr_n;
  logic [RAMP_BITS:0] gl_n, gr_n;
  logic settled_q;
  always_comb begin
    gl_n = (new_sample && sl == UP && gl < GMAX) ? gl + 1'b1 : (new_sample && sl == DOWN && gl != '0) ? gl - 1'b1 : gl;
    gr_n = (new_sample && sr == UP && gr < GMAX) ? gr + 1'b1 : (new_sample && sr == DOWN && gr != '0) ? gr - 1'b1 : gr;
    sl_n = gl_n < tl ? UP : gl_n > tl ? DOWN : HOLD;
    sr_n = gr_n < tr ? UP : gr_n > tr ? DOWN : HOLD;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      gl <= GMAX;
      gr <= GMAX;
      sl <= HOLD;
      sr <= HOLD;
      settled_q <= 1'b1;
    end else begin
      gl <= gl_n;
      gr <= gr_n;
      sl <= sl_n;
      sr <= sr_n;
      settled_q <= gl_n == tl && gr_n == tr;
    end
  end
  assign settled = settled_q;
`else
  assign gl = tl;
  assign gr = tr;
  assign settled = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      left_out <= '0;
      right_out <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= new_sample;
      if (new_sample) begin
        left_out <= scale(left_in, gl);
        right_out <= scale(right_in, gr);
      end
    end
  end
endmodule

// File: tb/tb_stereo_router.sv
// tb_stereo_router: directed checks of routing, scaling, strobe timing and reset for stereo_router
module tb_stereo_router;
  logic clk = 1'b0;
  logic rst, new_sample, out_valid, settled;
  logic [1:0] aural_state;
  logic [15:0] left_in, right_in, left_out, right_out;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  stereo_router #(.WIDTH(16), .RAMP_BITS(3)) dut (
    .clk(clk), .rst(rst), .aural_state(aural_state), .new_sample(new_sample),
    .left_in(left_in), .right_in(right_in), .left_out(left_out), .right_out(right_out),
    .out_valid(out_valid), .settled(settled)
  );
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic strobe(input int l, input int r);
    @(negedge clk);
    left_in = 16'(l);
    right_in = 16'(r);
    new_sample = 1'b1;
    @(negedge clk);
    new_sample = 1'b0;
  endtask
  task automatic expect_pair(input string tag, input int l, input int r);
    check({tag, " valid"}, int'(out_valid), 1);
    check({tag, " left"}, int'($signed(left_out)), l);
    check({tag, " right"}, int'($signed(right_out)), r);
  endtask
  initial begin
    rst = 1'b1;
    new_sample = 1'b0;
    aural_state = 2'b11;
    left_in = '0;
    right_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst left", int'(left_out), 0);
    check("rst right", int'(right_out), 0);
    check("rst valid", int'(out_valid), 0);
    check("rst settled", int'(settled), 1);
    strobe(1000, -1000);
    expect_pair("stereo", 1000, -1000);
    @(negedge clk);
    check("valid drop", int'(out_valid), 0);
    check("hold left", int'($signed(left_out)), 1000);
    strobe(5, -5);
    strobe(-32768, 32767);
    expect_pair("b2b", -32768, 32767);
`ifdef STEREO_ROUTER_RAMP_EN
    begin
      int rin[9] = '{800, 800, 800, 800, 800, -5, 800, 800, 800};
      int rexp[9] = '{800, 700, 600, 500, 400, -2, 200, 100, 0};
      aural_state = 2'b10;
      @(negedge clk);
      check("ramp settled fall", int'(settled), 0);
      check("ramp no out change", int'($signed(right_out)), 32767);
      for (int i = 0; i < 9; i++) begin
        strobe(100, rin[i]);
        expect_pair($sformatf("ramp%0d", i), 100, rexp[i]);
        check($sformatf("ramp%0d settled", i), int'(settled), i >= 7 ? 1 : 0);
      end
    end
    aural_state = 2'b11;
    repeat (10) strobe(8, 8);
    aural_state = 2'b01;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      strobe(8, 8);
      check($sformatf("rev down%0d", i), int'(left_out), 8 - i);
    end
    aural_state = 2'b11;
    @(negedge clk);
    check("rev settled", int'(settled), 0);
    for (int i = 0; i < 3; i++) begin
      strobe(8, 8);
      check($sformatf("rev up%0d", i), int'(left_out), 5 + i);
    end
    check("rev settled end", int'(settled), 1);
    strobe(8, 8);
    check("rev full", int'(left_out), 8);
    aural_state = 2'b00;
    strobe(8, 8);
    strobe(8, 8);
    check("pre-rst out", int'(left_out), 7);
    aural_state = 2'b11;
`else
    aural_state = 2'b10;
    @(negedge clk);
    check("chg no out change", int'($signed(left_out)), -32768);
    check("chg no valid", int'(out_valid), 0);
    strobe(300, 800);
    expect_pair("left only", 300, 0);
    aural_state = 2'b01;
    strobe(-7, 123);
    expect_pair("right only", 0, 123);
    aural_state = 2'b11;
    strobe(40, 40);
    aural_state = 2'b00;
    strobe(500, 500);
    expect_pair("mute", 0, 0);
    check("mute settled", int'(settled), 1);
    aural_state = 2'b11;
    strobe(8, 8);
`endif
    @(negedge clk);
    rst = 1'b1;
    new_sample = 1'b1;
    left_in = 16'd100;
    right_in = 16'd100;
    @(negedge clk);
    rst = 1'b0;
    new_sample = 1'b0;
    check("rst strobe valid", int'(out_valid), 0);
    check("rst strobe left", int'(left_out), 0);
    check("rst strobe right", int'(right_out), 0);
    check("rst strobe settled", int'(settled), 1);
    strobe(8, 8);
    expect_pair("post rst", 8, 8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
